// File: rtl/alu_mult_ctrl.sv
// Purpose : signed 32x32 multiply sequencer that borrows the shared single-cycle ALU for radix-2 Booth steps.
// Latency : ctrl_MULT at edge N -> busy in N+1..N+32, data_resultRDY pulse in N+33 (N+1 for a zero operand with MULT_EARLY_TERM_EN).
// Backpressure: none; ctrl_MULT is accepted in any state and aborts/restarts an in-flight multiply.
//
// Ports:
//   clock, reset                       rising-edge clock, synchronous active-high reset
//   ctrl_MULT, data_operandA/B         start pulse and two's-complement operands (sampled on the start edge)
//   alu_operandA/B, alu_opcode,        drive the shared ALU add/sub port while busy is high
//   alu_shiftamt
//   alu_result, alu_overflow           combinational ALU response consumed in the same cycle
//   data_result, data_exception        registered low product word / does-not-fit-in-32-bits flag
//   data_resultRDY, busy               one-cycle completion pulse / RUN-state indicator
//
// Optional feature: define MULT_EARLY_TERM_EN to finish immediately when either operand is zero.

module alu_mult_ctrl #(
    parameter int ITER = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] alu_operandA,
    output logic [31:0] alu_operandB,
    output logic [4:0]  alu_opcode,
    output logic [4:0]  alu_shiftamt,
    input  logic [31:0] alu_result,
    input  logic        alu_overflow,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SUB   = 5'b00001;
    localparam logic [4:0] CNT_LAST = 5'(ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_m;
    logic [31:0] r_p_hi;
    logic [31:0] r_p_lo;
    logic        r_q;
    logic [4:0]  r_cnt;
    logic [31:0] r_result;
    logic        r_exception;

    logic        w_early;
    logic        w_last;
    logic [32:0] w_sum;
    logic [31:0] w_p_hi_nxt;
    logic [31:0] w_p_lo_nxt;

`ifdef MULT_EARLY_TERM_EN
    assign w_early = (data_operandA == 32'd0) || (data_operandB == 32'd0);
`else
    assign w_early = 1'b0;
`endif

    assign w_last = (r_cnt == CNT_LAST);

    // The ALU only returns 32 bits; recover the true 33-bit sum by flipping
    // the result sign whenever the ALU flagged signed overflow.
    assign w_sum      = {alu_result[31] ^ alu_overflow, alu_result};

    // {S, P_lo, q} arithmetic-shifted right by one, kept to 65 bits.
    assign w_p_hi_nxt = w_sum[32:1];
    assign w_p_lo_nxt = {w_sum[0], r_p_lo[31:1]};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (ctrl_MULT) begin
            // A start always wins, even mid-RUN or in DONE.
            w_state_nxt = w_early ? S_DONE : S_RUN;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_IDLE;
                S_RUN:   w_state_nxt = w_last ? S_DONE : S_RUN;
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        alu_operandA   = 32'd0;
        alu_operandB   = 32'd0;
        alu_opcode     = OP_ADD;
        busy           = 1'b0;
        data_resultRDY = 1'b0;
        case (r_state)
            S_RUN: begin
                busy         = 1'b1;
                alu_operandA = r_p_hi;
                // Booth recoding of the current multiplier bit pair.
                case ({r_p_lo[0], r_q})
                    2'b01: begin
                        alu_opcode   = OP_ADD;
                        alu_operandB = r_m;
                    end
                    2'b10: begin
                        alu_opcode   = OP_SUB;
                        alu_operandB = r_m;
                    end
                    default: begin
                        alu_opcode   = OP_ADD;
                        alu_operandB = 32'd0;
                    end
                endcase
            end
            S_DONE: begin
                data_resultRDY = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign alu_shiftamt   = 5'd0;
    assign data_result    = r_result;
    assign data_exception = r_exception;

    // ---------------- datapath registers ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_m         <= 32'd0;
            r_p_hi      <= 32'd0;
            r_p_lo      <= 32'd0;
            r_q         <= 1'b0;
            r_cnt       <= 5'd0;
            r_result    <= 32'd0;
            r_exception <= 1'b0;
        end else if (ctrl_MULT) begin
            r_m    <= data_operandA;
            r_p_hi <= 32'd0;
            r_p_lo <= w_early ? 32'd0 : data_operandB;
            r_q    <= 1'b0;
            r_cnt  <= 5'd0;
            if (w_early) begin
                r_result    <= 32'd0;
                r_exception <= 1'b0;
            end
        end else if (r_state == S_RUN) begin
            r_p_hi <= w_p_hi_nxt;
            r_p_lo <= w_p_lo_nxt;
            r_q    <= r_p_lo[0];
            r_cnt  <= r_cnt + 5'd1;
            // Capture the product on the final step so it is already
            // visible during the DONE cycle and holds afterwards.
            if (w_last) begin
                r_result    <= w_p_lo_nxt;
                r_exception <= (w_p_hi_nxt != {32{w_p_lo_nxt[31]}});
            end
        end
    end

endmodule

// File: tb/tb_alu_mult_ctrl.sv
// Purpose : directed bench for alu_mult_ctrl with a behavioural combinational ALU on its add/sub port.
// Latency : checks the 33-cycle (or early-terminate) RDY timing and busy window of every operation.
// Backpressure: n/a; exercises restart, back-to-back start in DONE and reset mid-run.

module tb_alu_mult_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] alu_operandA;
    logic [31:0] alu_operandB;
    logic [4:0]  alu_opcode;
    logic [4:0]  alu_shiftamt;
    logic [31:0] alu_result;
    logic        alu_overflow;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int checks = 0;
    int errors = 0;

`ifdef MULT_EARLY_TERM_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 33;
`endif

    always #5 clock = ~clock;

    alu_mult_ctrl #(.ITER(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .alu_operandA   (alu_operandA),
        .alu_operandB   (alu_operandB),
        .alu_opcode     (alu_opcode),
        .alu_shiftamt   (alu_shiftamt),
        .alu_result     (alu_result),
        .alu_overflow   (alu_overflow),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    // Behavioural single-cycle ALU: 32-bit add/sub with signed overflow.
    always_comb begin
        logic [31:0] r;
        r = 32'd0;
        alu_overflow = 1'b0;
        if (alu_opcode == 5'b00001) begin
            r = alu_operandA - alu_operandB;
            alu_overflow = (alu_operandA[31] != alu_operandB[31]) && (r[31] != alu_operandA[31]);
        end else begin
            r = alu_operandA + alu_operandB;
            alu_overflow = (alu_operandA[31] == alu_operandB[31]) && (r[31] != alu_operandA[31]);
        end
        alu_result = r;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_result"}, data_result, 32'd0);
        chk({tag, "_exc"},    {31'd0, data_exception}, 32'd0);
        chk({tag, "_rdy"},    {31'd0, data_resultRDY}, 32'd0);
        chk({tag, "_busy"},   {31'd0, busy}, 32'd0);
        chk({tag, "_aluA"},   alu_operandA, 32'd0);
        chk({tag, "_aluB"},   alu_operandB, 32'd0);
        chk({tag, "_aluop"},  {27'd0, alu_opcode}, 32'd0);
        chk({tag, "_alush"},  {27'd0, alu_shiftamt}, 32'd0);
    endtask

    // Called at a negedge; returns at the negedge of cycle N+1 (N = sampling edge).
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT     = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
    endtask

    // Observes cycles N+1..N+lat; returns at the negedge of cycle N+lat.
    task automatic watch(input int lat, input logic [31:0] exp_res, input logic exp_exc, input string tag);
        int          rdy_at   = -1;
        int          rdy_n    = 0;
        int          busy_bad = 0;
        logic [31:0] res      = 32'hDEAD_BEEF;
        logic        exc      = 1'bx;
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) @(negedge clock);
            if (data_resultRDY === 1'b1) begin
                rdy_n++;
                rdy_at = k;
                res    = data_result;
                exc    = data_exception;
            end
            if (busy !== (k < lat)) busy_bad++;
        end
        chk({tag, "_rdy_cycle"}, rdy_at, lat);
        chk({tag, "_rdy_count"}, rdy_n, 1);
        chk({tag, "_busy_window"}, busy_bad, 0);
        chk({tag, "_result"}, res, exp_res);
        chk({tag, "_exc"}, {31'd0, exc}, {31'd0, exp_exc});
    endtask

    initial begin
        int rdy_n;
        int busy_n;

        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        repeat (3) @(negedge clock);
        chk_all_zero("reset_state");
        reset = 1'b0;
        @(negedge clock);

        // 3 x 5: first Booth step sees {1,0} -> subtract M=3 from P_hi=0.
        start(32'd3, 32'd5);
        chk("first_step_busy",  {31'd0, busy}, 32'd1);
        chk("first_step_op",    {27'd0, alu_opcode}, 32'd1);
        chk("first_step_aluA",  alu_operandA, 32'd0);
        chk("first_step_aluB",  alu_operandB, 32'd3);
        watch(33, 32'd15, 1'b0, "mul_3x5");
        @(negedge clock);
        chk("hold_result", data_result, 32'd15);
        chk("hold_rdy",    {31'd0, data_resultRDY}, 32'd0);
        chk("idle_aluA",   alu_operandA, 32'd0);
        chk("idle_aluB",   alu_operandB, 32'd0);

        // -7 x 6, then a new start issued in its DONE cycle.
        start(32'hFFFF_FFF9, 32'd6);
        watch(33, 32'hFFFF_FFD6, 1'b0, "mul_m7x6");
        start(32'h8000_0000, 32'hFFFF_FFFF);
        watch(33, 32'h8000_0000, 1'b1, "b2b_min_x_m1");
        @(negedge clock);

        start(32'h0001_0000, 32'h0001_0000);
        watch(33, 32'd0, 1'b1, "mul_2p16_sq");
        @(negedge clock);

        start(32'h8000_0000, 32'd1);
        watch(33, 32'h8000_0000, 1'b0, "mul_min_x_1");
        @(negedge clock);

        start(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        watch(33, 32'd1, 1'b1, "mul_max_sq");
        @(negedge clock);

        // Restart at N+10 with 4 x 4: no pulse from the aborted op.
        start(32'd3, 32'd5);
        rdy_n = 0;
        for (int k = 0; k < 9; k++) begin
            if (data_resultRDY === 1'b1) rdy_n++;
            @(negedge clock);
        end
        chk("restart_no_early_rdy", rdy_n, 0);
        start(32'd4, 32'd4);
        watch(33, 32'd16, 1'b0, "restart_4x4");
        @(negedge clock);

        // Reset sampled at edge N+20 of a running multiply.
        start(32'h0001_2345, 32'h0000_0777);
        repeat (19) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk_all_zero("midrun_reset");
        reset  = 1'b0;
        rdy_n  = 0;
        busy_n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) rdy_n++;
            if (busy === 1'b1) busy_n++;
        end
        chk("midrun_reset_no_rdy",  rdy_n, 0);
        chk("midrun_reset_no_busy", busy_n, 0);

        // Reset and start together: reset wins.
        reset         = 1'b1;
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd5;
        data_operandB = 32'd5;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        reset     = 1'b0;
        chk("rst_vs_start_busy", {31'd0, busy}, 32'd0);
        chk("rst_vs_start_rdy",  {31'd0, data_resultRDY}, 32'd0);
        @(negedge clock);
        chk("rst_vs_start_busy2", {31'd0, busy}, 32'd0);

        // Zero operand: immediate completion only with early termination.
        start(32'd0, 32'd1234);
        watch(ZERO_LAT, 32'd0, 1'b0, "zero_operand");
        @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mult_ctrl.md
# alu_mult_ctrl

Multi-cycle signed 32×32 multiply sequencer that reuses the processor's single-cycle ALU instead of a dedicated multiplier. It runs radix-2 Booth recoding over 32 iterations. Each iteration drives the ALU's add/sub port to update the upper half of an internal 65-bit product register, then arithmetic-shifts that register internally. It sits between the execute stage (issues `ctrl_MULT`, waits for `data_resultRDY`) and the shared ALU, whose add/sub inputs it owns while `busy` is high.

## Interface
Parameters:
- `ITER`, 32: Booth iterations; equals operand width and is fixed by the ALU width.

Ports:
- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `ctrl_MULT`  in  1  start pulse; operands sampled same edge
- `data_operandA`  in  32  multiplicand, two's complement
- `data_operandB`  in  32  multiplier, two's complement
- `alu_operandA`  out  32  to ALU A: current P_hi
- `alu_operandB`  out  32  to ALU B: multiplicand M or 0
- `alu_opcode`  out  5  5'b00000 add / 5'b00001 sub
- `alu_shiftamt`  out  5  constant 0
- `alu_result`  in  32  ALU sum/difference
- `alu_overflow`  in  1  ALU signed overflow of that op
- `data_result`  out  32  low 32 bits of product
- `data_exception`  out  1  product does not fit in signed 32 bits
- `data_resultRDY`  out  1  one-cycle completion pulse
- `busy`  out  1  high in RUN

## Operation
- State registers: M[31:0], P[64:0] = {P_hi[31:0], P_lo[31:0], q}, 5-bit counter `cnt`, FSM {IDLE, RUN, DONE}.
- Start (`ctrl_MULT`=1, any state):
  - load M←A, P_hi←0, P_lo←B, q←0, cnt←0
  - go to RUN
- Start has priority over all other transitions; a start in RUN or DONE aborts and restarts with the new operands.
- RUN, per cycle, select on {P_lo[0], q}:
  - 01: opcode add, alu_operandB=M
  - 10: opcode sub, alu_operandB=M
  - 00/11: opcode add, alu_operandB=0
- RUN register update: 33-bit true sum S = {alu_result[31]^alu_overflow, alu_result}; P ← {S, P_lo, q} >>> 1, sign-filled from S[32].
- RUN exit: cnt increments; after the iteration with cnt==31, go to DONE.
- DONE:
  - `data_resultRDY`=1 for this single cycle
  - `data_result`=P_lo
  - `data_exception` = 1 iff P_hi != {32{P_lo[31]}}
  - next state IDLE
- `data_result` and `data_exception` are registered and hold their values until the next DONE, or until reset.
- `alu_*` outputs in IDLE/DONE: operandA=0, operandB=0, opcode add. The ALU is free for others; the external mux is keyed on `busy`.
- Reset values:
  - state IDLE, all data registers 0
  - `data_result`=0, `data_exception`=0, `data_resultRDY`=0, `busy`=0
  - `alu_operandA`=0, `alu_operandB`=0, `alu_opcode`=0, `alu_shiftamt`=0

## Timing
- `ctrl_MULT` sampled at edge N; RUN occupies cycles N+1..N+32; `data_resultRDY` high during cycle N+33 only. Total latency is 33 cycles.
- `busy` is high exactly in cycles N+1..N+32.
- The ALU is combinational: `alu_result` is consumed in the same cycle the controller drives `alu_*`. No ALU pipeline registers are allowed on this path.
- Back-to-back: `ctrl_MULT` in the DONE cycle N+33 is accepted; the RDY pulse still occurs in N+33, and the new RUN starts at N+34.
- Reset in any state, including mid-RUN, returns to IDLE at the next edge. The in-flight operation is dropped with no RDY pulse.
- Reset and `ctrl_MULT` asserted in the same cycle: reset wins.

## Configuration
- `MULT_EARLY_TERM_EN` defined:
  - At start, if A==0 or B==0, the FSM goes directly to DONE with P cleared.
  - `data_resultRDY` is high in cycle N+1; result 0, exception 0; `busy` never asserts.
- Undefined: every operation takes the full 32 iterations (RDY at N+33) regardless of operand values.

## Test plan
- A=3, B=5, start at cycle N -> `data_resultRDY` only in N+33; result 15; exception 0; `busy` high exactly N+1..N+32.
- A=-7 (0xFFFFFFF9), B=6 -> result 0xFFFFFFD6 (-42), exception 0.
- A=0x80000000, B=0xFFFFFFFF -> result 0x80000000, exception 1. Exercises ALU overflow sign correction.
- A=0x00010000, B=0x00010000 -> result 0, exception 1. Second case: A=0x80000000, B=1 -> result 0x80000000, exception 0.
- Start A=3,B=5; restart at N+10 with A=4,B=4 -> single RDY at N+43, result 16. Separately, reset at N+20 -> no RDY, all outputs 0 at N+21.
- With `MULT_EARLY_TERM_EN`: A=0, B=1234 -> RDY at N+1, result 0. Without the macro, the same stimulus gives RDY at N+33.
